axi_write_arbiter: RTL

- Write-channel counterpart of the bus read arbiter: grants the AW/W/B path of one of three masters (M0, M1, M2) to one decoded slave (S0..S7) or to the default/decode-error slave.
- Holds the grant from address acceptance through the last W beat and the B handshake, then releases it.
- Drives AW_arbiter, which steers the crossbar write muxes.
- AW_arbiter is also fed to the read arbiter, which blocks M1 reads while AW_arbiter != Default_W.

---
 rtl/axi_bus_pkg.sv | 64 ++++++
 rtl/axi_write_arbiter_rr_priority3.sv | 47 ++++
 rtl/axi_write_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_bus_pkg.sv
// Shared AXI crossbar definitions: FSM states, slave indices, address decode
// and the (master, slave) <-> grant-code mapping used by both bus arbiters.
// Grant codes: 0 is the default/no-grant code; otherwise 1 + 9*master + slave.
// NO (slot 8) selects the decode-error slave.
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef MX_SX_ID_BITS
`define MX_SX_ID_BITS 5
`endif

package axi_bus_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} wr_state_e;

    typedef enum logic [3:0] {S0, S1, S2, S3, S4, S5, S6, S7, NO} slave_e;

    localparam int NUM_SLOTS = 9;
    localparam logic [`MX_SX_ID_BITS-1:0] DEFAULT_W = '0;

    typedef struct packed {
        logic       valid;
        logic [1:0] master;
        slave_e     slave;
    } grant_t;

    function automatic slave_e addr_to_slave(input logic [31:0] addr);
        slave_e s;
        case (addr[31:16])
            16'h0000: s = S0;
            16'h0001: s = S1;
            16'h0002: s = S2;
            16'h1000: s = S3;
            16'h1001: s = S4;
            16'h0010: s = S6;
            16'h0003: s = S7;
            default:  s = (addr[31:24] == 8'h20) ? S5 : NO;
        endcase
        return s;
    endfunction

    function automatic logic [`MX_SX_ID_BITS-1:0] grant_encode(input logic [1:0] master,
                                                                input slave_e   slave);
        int code;
        code = 1 + NUM_SLOTS * int'(master) + int'(slave);
        return code[`MX_SX_ID_BITS-1:0];
    endfunction

    function automatic grant_t grant_decode(input logic [`MX_SX_ID_BITS-1:0] code);
        grant_t g;
        int     idx;
        g.valid  = 1'b0;
        g.master = 2'd0;
        g.slave  = NO;
        if (code != DEFAULT_W && int'(code) <= 3 * NUM_SLOTS) begin
            idx      = int'(code) - 1;
            g.valid  = 1'b1;
            g.master = 2'(idx / NUM_SLOTS);
            g.slave  = slave_e'(4'(idx % NUM_SLOTS));
        end
        return g;
    endfunction

endpackage

// File: rtl/axi_write_arbiter_rr_priority3.sv
// Three-request picker: round-robin from a rotating pointer, or fixed
// priority 0 > 1 > 2. The pointer moves past the served master on advance.
module rr_priority3
    import axi_bus_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       advance,
    input  logic [1:0] served,
    output logic       gnt_valid,
    output logic [1:0] gnt_idx
);

    logic [1:0] ptr_q, ptr_d;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Scan the three requests starting from the pointer (or from M0) and take the first.
    always_comb begin
        logic [1:0] cand;
        logic       found;
        gnt_idx = 2'd0;
        found   = 1'b0;
        cand    = RR_EN ? ptr_q : 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!found && req[cand]) begin
                gnt_idx = cand;
                found   = 1'b1;
            end
            cand = next_idx(cand);
        end
        gnt_valid = found;
        ptr_d     = advance ? next_idx(served) : ptr_q;
    end

    // Pointer register; restarts at M0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 2'd0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/axi_write_arbiter.sv
// Write-channel arbiter: grants the AW/W/B path of one of three masters to one
// decoded slave, holding it until the B handshake completes.
// Optional build macro AXI_WR_TIMEOUT_EN adds a stall watchdog and wr_timeout.
module axi_write_arbiter
    import axi_bus_pkg::*;
#(
    parameter bit RR_EN = 1'b1,
    parameter int LEN_W = `AXI_LEN_BITS
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [31:0]               AWADDR_M0,
    input  logic [31:0]               AWADDR_M1,
    input  logic [31:0]               AWADDR_M2,
    input  logic [LEN_W-1:0]          AWLEN_M0,
    input  logic [LEN_W-1:0]          AWLEN_M1,
    input  logic [LEN_W-1:0]          AWLEN_M2,
    input  logic                      AWVALID_M0,
    input  logic                      AWVALID_M1,
    input  logic                      AWVALID_M2,
    input  logic                      AWREADY_M0,
    input  logic                      AWREADY_M1,
    input  logic                      AWREADY_M2,
    input  logic                      WVALID_M0,
    input  logic                      WVALID_M1,
    input  logic                      WVALID_M2,
    input  logic                      WREADY_M0,
    input  logic                      WREADY_M1,
    input  logic                      WREADY_M2,
    input  logic                      WLAST_M0,
    input  logic                      WLAST_M1,
    input  logic                      WLAST_M2,
    input  logic                      BVALID_M0,
    input  logic                      BVALID_M1,
    input  logic                      BVALID_M2,
    input  logic                      BREADY_M0,
    input  logic                      BREADY_M1,
    input  logic                      BREADY_M2,
    input  logic [`MX_SX_ID_BITS-1:0] AR_arbiter,
    output logic [`MX_SX_ID_BITS-1:0] AW_arbiter,
    output logic                      wr_len_err
`ifdef AXI_WR_TIMEOUT_EN
    ,
    output logic                      wr_timeout
`endif
);

    logic [31:0]      aw_addr [3];
    logic [LEN_W-1:0] aw_len  [3];
    logic [2:0]       aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;

    assign aw_addr  = '{AWADDR_M0, AWADDR_M1, AWADDR_M2};
    assign aw_len   = '{AWLEN_M0, AWLEN_M1, AWLEN_M2};
    assign aw_valid = {AWVALID_M2, AWVALID_M1, AWVALID_M0};
    assign aw_ready = {AWREADY_M2, AWREADY_M1, AWREADY_M0};
    assign w_valid  = {WVALID_M2, WVALID_M1, WVALID_M0};
    assign w_ready  = {WREADY_M2, WREADY_M1, WREADY_M0};
    assign w_last   = {WLAST_M2, WLAST_M1, WLAST_M0};
    assign b_valid  = {BVALID_M2, BVALID_M1, BVALID_M0};
    assign b_ready  = {BREADY_M2, BREADY_M1, BREADY_M0};

    wr_state_e        state_q, state_d;
    logic [1:0]       gnt_m_q, gnt_m_d;
    slave_e           gnt_s_q, gnt_s_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W:0]   cnt_q, cnt_d;
    logic             len_err_q, len_err_d;

    slave_e     req_slave [3];
    logic [2:0] elig;
    logic       gnt_valid;
    logic [1:0] win_idx;
    logic       rr_advance;

    logic [1:0]       sel_m;
    logic             cur_awhs, cur_whs, cur_wlast, cur_bhs;
    logic [LEN_W-1:0] beat_len;
    logic [LEN_W:0]   beat_idx, cnt_inc;
    logic             beat_err, w_counted;

`ifdef AXI_WR_TIMEOUT_EN
    logic [9:0] tmo_q, tmo_d;
    logic       timeout_q, timeout_d;
`endif

    // A master competes only if it requests and its target is not already held by its own read.
    always_comb begin
        elig = '0;
        for (int m = 0; m < 3; m++) begin
            req_slave[m] = addr_to_slave(aw_addr[m]);
            elig[m]      = aw_valid[m] && (AR_arbiter != grant_encode(2'(m), req_slave[m]));
        end
    end

    rr_priority3 #(.RR_EN(RR_EN)) u_pick (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .req       (elig),
        .advance   (rr_advance),
        .served    (gnt_m_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (win_idx)
    );

    // Handshakes of the master in focus, and whether the current W beat breaks the burst length.
    always_comb begin
        sel_m     = (state_q == IDLE) ? win_idx : gnt_m_q;
        cur_awhs  = aw_valid[sel_m] && aw_ready[sel_m];
        cur_whs   = w_valid[sel_m] && w_ready[sel_m];
        cur_wlast = w_last[sel_m];
        cur_bhs   = b_valid[sel_m] && b_ready[sel_m];
        beat_len  = (state_q == IDLE) ? aw_len[win_idx] : len_q;
        beat_idx  = (state_q == DATA) ? cnt_q : '0;
        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        beat_err  = cur_whs && ((cur_wlast && beat_idx != {1'b0, beat_len}) ||
                                (!cur_wlast && beat_idx == {1'b0, beat_len}));
        case (state_q)
            IDLE:    w_counted = gnt_valid && cur_awhs;
            ADDR:    w_counted = cur_awhs;
            DATA:    w_counted = 1'b1;
            default: w_counted = 1'b0;
        endcase
    end

    // Next-state and burst bookkeeping; the first W beat may ride along with the AW handshake.
    always_comb begin
        state_d    = state_q;
        gnt_m_d    = gnt_m_q;
        gnt_s_d    = gnt_s_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        len_err_d  = len_err_q | (w_counted && beat_err);
        rr_advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    gnt_m_d = win_idx;
                    gnt_s_d = req_slave[win_idx];
                    len_d   = aw_len[win_idx];
                    cnt_d   = '0;
                    state_d = ADDR;
                    if (cur_awhs) begin
                        cnt_d   = {{LEN_W{1'b0}}, cur_whs};
                        state_d = (cur_whs && cur_wlast) ? RESP : DATA;
                    end
                end
            end
            ADDR: begin
                if (cur_awhs) begin
                    cnt_d   = {{LEN_W{1'b0}}, cur_whs};
                    state_d = (cur_whs && cur_wlast) ? RESP : DATA;
                end
            end
            DATA: begin
                if (cur_whs) begin
                    cnt_d = cnt_inc;
                    if (cur_wlast) state_d = RESP;
                end
            end
            RESP: begin
                if (cur_bhs) begin
                    state_d    = IDLE;
                    rr_advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef AXI_WR_TIMEOUT_EN
        timeout_d = timeout_q;
        if (state_q == IDLE || cur_awhs || cur_whs || cur_bhs) tmo_d = '0;
        else                                                   tmo_d = tmo_q + 10'd1;
        if (state_q != IDLE && tmo_q == 10'h3FF) begin
            state_d    = IDLE;
            rr_advance = 1'b1;
            timeout_d  = 1'b1;
            tmo_d      = '0;
        end
`endif
    end

    // Arbiter state; reset abandons any burst in flight.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            gnt_m_q   <= 2'd0;
            gnt_s_q   <= NO;
            len_q     <= '0;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
`ifdef AXI_WR_TIMEOUT_EN
            tmo_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_m_q   <= gnt_m_d;
            gnt_s_q   <= gnt_s_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
`ifdef AXI_WR_TIMEOUT_EN
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Grant code: live winner while idle (zero latency), held registered grant otherwise.
    always_comb begin
        AW_arbiter = DEFAULT_W;
        if (!ARESETn)             AW_arbiter = DEFAULT_W;
        else if (state_q == IDLE) AW_arbiter = gnt_valid ? grant_encode(win_idx, req_slave[win_idx]) : DEFAULT_W;
        else                      AW_arbiter = grant_encode(gnt_m_q, gnt_s_q);
    end

    assign wr_len_err = len_err_q;
`ifdef AXI_WR_TIMEOUT_EN
    assign wr_timeout = timeout_q;
`endif

endmodule
